// File: rtl/bram32_wb_slave.sv
// Wishbone classic slave in front of a 32-bit single-port block RAM without byte enables.
// Partial-lane writes become read-merge-write; `define BRAM32_WB_SLAVE_ERR_EN to err-ack out-of-range addresses.
module bram32_wb_slave #(
  parameter int adr_width = 11
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [15:0] bram_a,
  output logic        bram_we,
  output logic [31:0] bram_do,
  input  logic [31:0] bram_di
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRB, ACK} state_t;

  state_t      state, state_nxt;
  logic        req_we, req_we_nxt;
  logic [3:0]  req_sel, req_sel_nxt;
  logic [31:0] req_dat, req_dat_nxt;
  logic [31:0] dat_o_nxt, bram_do_nxt, merged;
  logic [15:0] bram_a_nxt;
  logic        ack_nxt, err_nxt, bram_we_nxt;
  logic        start, adr_bad, full_wr;

  assign start   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign full_wr = req_we & (req_sel == 4'hF);

`ifdef BRAM32_WB_SLAVE_ERR_EN
  assign adr_bad = |wb_adr_i[15:adr_width];
`else
  assign adr_bad = 1'b0;
`endif

  // Unselected lanes keep the word the RAM just returned.
  always_comb begin
    merged = bram_di;
    for (int i = 0; i < 4; i++)
      if (req_sel[i]) merged[8*i +: 8] = req_dat[8*i +: 8];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = adr_bad ? ACK : ISSUE;
      ISSUE:   if (!wb_cyc_i) state_nxt = IDLE;
               else           state_nxt = full_wr ? ACK : WAIT;
      WAIT:    if (!wb_cyc_i) state_nxt = IDLE;
               else           state_nxt = req_we ? WRB : ACK;
      WRB:     state_nxt = wb_cyc_i ? ACK : IDLE;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dat_o_nxt   = wb_dat_o;
    ack_nxt     = wb_ack_o;
    err_nxt     = wb_err_o;
    bram_a_nxt  = bram_a;
    bram_we_nxt = bram_we;
    bram_do_nxt = bram_do;
    req_we_nxt  = req_we;
    req_sel_nxt = req_sel;
    req_dat_nxt = req_dat;
    case (state)
      IDLE:
        if (start) begin
          if (adr_bad) begin
            err_nxt = 1'b1;
          end else begin
            bram_a_nxt  = wb_adr_i;
            bram_do_nxt = wb_dat_i;
            bram_we_nxt = wb_we_i & (wb_sel_i == 4'hF);
            req_we_nxt  = wb_we_i;
            req_sel_nxt = wb_sel_i;
            req_dat_nxt = wb_dat_i;
          end
        end
      ISSUE: begin
        bram_we_nxt = 1'b0;
        if (wb_cyc_i && full_wr) ack_nxt = 1'b1;
      end
      WAIT:
        if (wb_cyc_i) begin
          if (req_we) begin
            bram_do_nxt = merged;
            bram_we_nxt = 1'b1;
          end else begin
            dat_o_nxt = bram_di;
            ack_nxt   = 1'b1;
          end
        end
      WRB: begin
        bram_we_nxt = 1'b0;
        if (wb_cyc_i) ack_nxt = 1'b1;
      end
      ACK: begin
        ack_nxt = 1'b0;
        err_nxt = 1'b0;
      end
      default: bram_we_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      bram_a   <= '0;
      bram_we  <= 1'b0;
      bram_do  <= '0;
      req_we   <= 1'b0;
      req_sel  <= '0;
      req_dat  <= '0;
    end else begin
      wb_dat_o <= dat_o_nxt;
      wb_ack_o <= ack_nxt;
      wb_err_o <= err_nxt;
      bram_a   <= bram_a_nxt;
      bram_we  <= bram_we_nxt;
      bram_do  <= bram_do_nxt;
      req_we   <= req_we_nxt;
      req_sel  <= req_sel_nxt;
      req_dat  <= req_dat_nxt;
    end

endmodule

// File: tb/tb_bram32_wb_slave.sv
// Scoreboard bench for bram32_wb_slave with a behavioural 1-cycle-read RAM attached.
module tb_bram32_wb_slave;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [15:0] wb_adr_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [15:0] bram_a;
  logic        bram_we;
  logic [31:0] bram_do;
  logic [31:0] bram_di;

  bram32_wb_slave #(.adr_width(11)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .bram_a(bram_a), .bram_we(bram_we), .bram_do(bram_do), .bram_di(bram_di)
  );

  always #5 sys_clk = ~sys_clk;

  // RAM model plus a back-door preload port
  logic [31:0] mem [512];
  logic        pre_en = 1'b0;
  logic [8:0]  pre_idx = '0;
  logic [31:0] pre_dat = '0;
  always @(posedge sys_clk) begin
    if (pre_en)       mem[pre_idx] <= pre_dat;
    else if (bram_we) mem[bram_a[10:2]] <= bram_do;
    bram_di <= mem[bram_a[10:2]];
  end

  int cyc_cnt = 0;
  int we_cnt = 0;
  always @(posedge sys_clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (bram_we) we_cnt <= we_cnt + 1;
  end

  typedef struct { logic err; logic [31:0] dat; int cyc; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, resp_cnt = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack/err the DUT presents must match the next expected response
  always @(negedge sys_clk) begin : monitor
    exp_t e;
    if (sys_rst_n && (wb_ack_o || wb_err_o)) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp ack=%b err=%b t=%0t", wb_ack_o, wb_err_o, $time);
      end else begin
        e = sb.pop_front();
        chk("resp_err", {31'd0, wb_err_o}, {31'd0, e.err});
        chk("resp_ack", {31'd0, wb_ack_o}, {31'd0, !e.err});
        chk("resp_dat", wb_dat_o, e.dat);
        chk("resp_latency", 32'(cyc_cnt), 32'(e.cyc));
      end
      resp_cnt++;
    end
  end

  task automatic preload(input int idx, input logic [31:0] d);
    @(negedge sys_clk); #1;
    pre_en = 1'b1; pre_idx = 9'(idx); pre_dat = d;
    @(negedge sys_clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic req(input logic we, input logic [15:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat);
    @(negedge sys_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
  endtask

  task automatic idle_bus();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic txn(input logic we, input logic [15:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat, input logic err, input logic [31:0] exp_dat,
                     input int lat, input int exp_we);
    int r0, w0;
    bit got;
    r0 = resp_cnt; w0 = we_cnt; got = 1'b0;
    req(we, adr, sel, dat);
    sb.push_back('{err, exp_dat, cyc_cnt + 1 + lat});
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge sys_clk); #1;
      if (resp_cnt != r0) got = 1'b1;
    end
    idle_bus();
    if (!got) begin
      checks++; errors++;
      $display("FAIL resp_timeout adr=%h got=none required=response", adr);
      sb.delete();
    end
    repeat (3) @(negedge sys_clk);
    chk("we_pulses", 32'(we_cnt - w0), 32'(exp_we));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ack"}, {31'd0, wb_ack_o}, 32'd0);
    chk({tag, "_err"}, {31'd0, wb_err_o}, 32'd0);
    chk({tag, "_we"},  {31'd0, bram_we}, 32'd0);
    chk({tag, "_dat_o"}, wb_dat_o, 32'd0);
    chk({tag, "_bram_a"}, {16'd0, bram_a}, 32'd0);
    chk({tag, "_bram_do"}, bram_do, 32'd0);
  endtask

  initial begin : stim
    int w0, r0;
    repeat (3) @(negedge sys_clk);
    chk_outputs_zero("reset");
    @(negedge sys_clk); #1;
    sys_rst_n = 1'b1;

    // Read
    preload(5, 32'hDEADBEEF);
    txn(1'b0, 16'h0014, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 2, 0);
    last_rd = 32'hDEADBEEF;

    // Full write then readback; wb_dat_o holds the last read value on writes
    txn(1'b1, 16'h0008, 4'hF, 32'h12345678, 1'b0, last_rd, 1, 1);
    txn(1'b0, 16'h0008, 4'hF, 32'h0, 1'b0, 32'h12345678, 2, 0);
    last_rd = 32'h12345678;

    // Partial write: lanes 0 and 2 from the bus
    preload(3, 32'hAABBCCDD);
    txn(1'b1, 16'h000C, 4'b0101, 32'h11223344, 1'b0, last_rd, 3, 1);
    txn(1'b0, 16'h000C, 4'hF, 32'h0, 1'b0, 32'hAA22CC44, 2, 0);
    last_rd = 32'hAA22CC44;

    // sel=0 write rewrites the old word unchanged
    txn(1'b1, 16'h000C, 4'b0000, 32'hFFFFFFFF, 1'b0, last_rd, 3, 1);
    txn(1'b0, 16'h000C, 4'hF, 32'h0, 1'b0, 32'hAA22CC44, 2, 0);

    // Top lane only, byte offset in address ignored
    preload(4, 32'h00000000);
    txn(1'b1, 16'h0013, 4'b1000, 32'h9A000000, 1'b0, last_rd, 3, 1);
    txn(1'b0, 16'h0010, 4'hF, 32'h0, 1'b0, 32'h9A000000, 2, 0);
    last_rd = 32'h9A000000;

    // Abort: drop cyc while in WAIT
    preload(7, 32'h55667788);
    w0 = we_cnt; r0 = resp_cnt;
    req(1'b1, 16'h001C, 4'b0011, 32'h99999999);
    @(negedge sys_clk); #1;
    @(negedge sys_clk); #1;
    idle_bus();
    repeat (5) @(negedge sys_clk);
    chk("abort_we_pulses", 32'(we_cnt - w0), 32'd0);
    chk("abort_acks", 32'(resp_cnt - r0), 32'd0);
    chk("abort_mem", mem[7], 32'h55667788);
    txn(1'b0, 16'h001C, 4'hF, 32'h0, 1'b0, 32'h55667788, 2, 0);
    last_rd = 32'h55667788;

    // Reset while in WRB with the merged write on bram_we
    preload(9, 32'h01020304);
    w0 = we_cnt;
    req(1'b1, 16'h0024, 4'b1110, 32'hA0B0C0D0);
    repeat (3) begin @(negedge sys_clk); #1; end
    chk("wrb_we_high", {31'd0, bram_we}, 32'd1);
    sys_rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    idle_bus();
    @(negedge sys_clk); #1;
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("midrst_we_pulses", 32'(we_cnt - w0), 32'd0);
    chk("midrst_mem", mem[9], 32'h01020304);
    txn(1'b0, 16'h0014, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 2, 0);
    last_rd = 32'hDEADBEEF;

    // Out-of-range address
`ifdef BRAM32_WB_SLAVE_ERR_EN
    txn(1'b0, 16'h0800, 4'hF, 32'h0, 1'b1, last_rd, 1, 0);
`else
    preload(0, 32'hCAFEF00D);
    txn(1'b0, 16'h0800, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D, 2, 0);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram32_wb_slave.md
Name: bram32_wb_slave

Overview:
- Wishbone classic slave that sits directly upstream of the 32-bit single-port block RAM and drives its address, write-enable and write-data inputs.
- The RAM has no byte enables and a 1-cycle synchronous read, so this block converts Wishbone byte-select writes into read-merge-write sequences.
- It also returns read data to the bus and generates the ack. It connects the CPU/interconnect to on-chip program/data RAM.

Parameters:
- adr_width, 11, byte-address bits decoded by the attached RAM; RAM word address = adr[adr_width-1:2].

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  16  byte address.
- wb_sel_i  in  4  byte lane selects; bit0 = dat[7:0].
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  one-cycle acknowledge, registered.
- wb_err_o  out  1  error acknowledge (see Optional Feature).
- bram_a  out  16  to RAM address input, registered.
- bram_we  out  1  to RAM write enable, registered.
- bram_do  out  32  to RAM write-data input, registered.
- bram_di  in  32  from RAM read data; valid the cycle after the read edge.

Behaviour:
- Async reset (sys_rst_n low):
  - state = IDLE.
  - wb_dat_o, wb_ack_o, wb_err_o, bram_a, bram_we, bram_do all 0.
  - Reset deassertion takes effect on the next edge.
- States are IDLE, ISSUE, WAIT, WRB and ACK.
- IDLE: at an edge E0 with cyc & stb & !ack:
  - bram_a <= wb_adr_i and bram_do <= wb_dat_i.
  - bram_we <= we & (sel==4'hF).
  - The request fields are captured in internal registers (we, sel, dat).
  - Next state is ISSUE.
- ISSUE (edge E1, where the RAM performs the access):
  - bram_we <= 0.
  - For a full write: wb_ack_o <= 1, next state ACK.
  - For a read or partial write (sel != F, including sel=0): next state WAIT.
- WAIT (edge E2, with bram_di valid):
  - Read: wb_dat_o <= bram_di, wb_ack_o <= 1, next state ACK.
  - Partial write: bram_do byte i <= sel[i] ? dat byte i : bram_di byte i; bram_we <= 1; next state WRB.
  - sel=0 write: merged value equals old word, so the rewrite is harmless.
- WRB (edge E3, where the RAM commits the merged word): bram_we <= 0, wb_ack_o <= 1, next state ACK.
- ACK: wb_ack_o <= 0, next state IDLE. A new request is sampled in IDLE at the following edge, so there is no back-to-back ack.
- Ack latency, counted from the sampling edge E0 to ack high:
  - full write: 1 edge.
  - read: 2 edges.
  - partial write: 3 edges.
- wb_dat_o holds its last read value until the next read; it is undefined for writes by protocol, but is not changed by them.
- Abort: if wb_cyc_i is low at any edge in ISSUE, WAIT or WRB:
  - next state IDLE, bram_we <= 0, no ack.
  - A write already presented on bram_we at that edge is committed by the RAM (full write in ISSUE, merged write in WRB). No partial merge is ever half-written.
- wb_stb_i low mid-transaction is ignored; only cyc aborts.
- Upper address bits wb_adr_i[15:adr_width] are passed through on bram_a; the RAM ignores them.
- bram_a[1:0] follows wb_adr_i; byte offset is ignored, and lanes come only from sel.

Optional Feature:
- Macro: BRAM32_WB_SLAVE_ERR_EN.
- Defined:
  - At E0, if wb_adr_i[15:adr_width] != 0, the block performs no RAM access (bram_we stays 0) and goes to ACK with wb_err_o <= 1 instead of wb_ack_o.
  - wb_err_o is a 1-cycle pulse after E0 and clears in ACK.
  - wb_dat_o is unchanged.
- Not defined:
  - wb_err_o is tied to 0.
  - Out-of-range addresses alias into the RAM, with normal ack timing.

Test Plan:
- Read:
  - Preload word 5 = 32'hDEADBEEF; read adr 16'h0014.
  - Expect ack high exactly 2 edges after stb is sampled, with wb_dat_o = 32'hDEADBEEF.
  - bram_we must never be asserted.
- Full write:
  - Write adr 16'h0008, sel F, data 32'h12345678.
  - Expect bram_we high for exactly 1 cycle and ack 1 edge after sampling.
  - Readback gives 32'h12345678.
- Partial write:
  - Word 3 = 32'hAABBCCDD; write adr 16'h000C, sel 4'b0101, data 32'h11223344.
  - Expect ack 3 edges after sampling and a single bram_we pulse.
  - Readback gives 32'hAA22CC44.
- Abort:
  - Start a partial write, then drop cyc in WAIT.
  - Expect no ack, bram_we never asserted, and the word unchanged.
  - The next read acks normally.
- Reset mid-operation:
  - Assert sys_rst_n low in WRB asynchronously.
  - All outputs go to 0 immediately and state returns to IDLE.
  - After release, a read completes with 2-edge latency.
- Error (BRAM32_WB_SLAVE_ERR_EN defined, adr_width=11):
  - Read adr 16'h0800: expect wb_err_o pulse 1 edge after sampling, no ack, bram_we never asserted.
  - With the macro undefined: ack after 2 edges, returning word 0.
